// File: rtl/fetch_unit_s00_axis_pkg.sv
// Shared types and constants for the fetch unit AXI4-Stream slave.
package fetch_unit_s00_axis_pkg;

  localparam int unsigned ColBitsDefault = 5;

  typedef enum logic [1:0] {
    SelMatA  = 2'd0,
    SelMatB  = 2'd1,
    SelInstr = 2'd2,
    SelNone  = 2'd3
  } sel_e;

  typedef enum logic [0:0] {
    StRecv = 1'b0,
    StDone = 1'b1
  } state_e;

  // Zero every byte whose strobe bit is clear.
  function automatic logic [31:0] strb_mask(input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_unit_s00_axis_if.sv
// AXI4-Stream beat channel between a stream source and the fetch unit.
interface fetch_unit_s00_axis_if #(
  parameter int unsigned DataWidth = 32
);
  logic [DataWidth-1:0]   TDATA;
  logic [DataWidth/8-1:0] TSTRB;
  logic                   TLAST;
  logic                   TVALID;
  logic                   TREADY;

  modport master (
    output TDATA,
    output TSTRB,
    output TLAST,
    output TVALID,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TSTRB,
    input  TLAST,
    input  TVALID,
    output TREADY
  );
endinterface

// File: rtl/fetch_unit_s00_axis_addr_gen.sv
// Row/column and linear write-address counters for the fetch unit.
module fetch_addr_gen
  import fetch_unit_s00_axis_pkg::*;
#(
  parameter int unsigned BramDepth  = 10,
  parameter int unsigned InstrDepth = 11,
  parameter int unsigned ColBits    = ColBitsDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  beat_i,
  input  logic                  last_i,
  input  logic [31:0]           width_i,
  output logic [BramDepth-1:0]  mat_addr_o,
  output logic [InstrDepth-1:0] instr_addr_o
);

  localparam int unsigned RowBits = BramDepth - ColBits;
  localparam logic [31:0] MaxW = 32'(1) << ColBits;
  localparam logic [ColBits:0] One = (ColBits + 1)'(1);

  logic [ColBits-1:0]    col_q, col_d;
  logic [RowBits-1:0]    row_q, row_d;
  logic [InstrDepth-1:0] lin_q, lin_d;
  logic [ColBits:0]      eff_w;

  // A zero row width behaves as one element per row; wide rows saturate.
  always_comb begin
    if (width_i == '0) begin
      eff_w = One;
    end else if (width_i > MaxW) begin
      eff_w = MaxW[ColBits:0];
    end else begin
      eff_w = width_i[ColBits:0];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    lin_d = lin_q;
    if (beat_i) begin
      if (last_i) begin
        col_d = '0;
        row_d = '0;
        lin_d = '0;
      end else begin
        lin_d = lin_q + InstrDepth'(1);
        if ({1'b0, col_q} == eff_w - One) begin
          col_d = '0;
          row_d = row_q + RowBits'(1);
        end else begin
          col_d = col_q + ColBits'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
      lin_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      lin_q <= lin_d;
    end
  end

  assign mat_addr_o   = {row_q, col_q};
  assign instr_addr_o = lin_q;

endmodule

// File: rtl/fetch_unit_s00_axis.sv
// AXI4-Stream slave that scatters packet words into matrix A/B and instruction BRAMs.
// Optional FETCH_UNIT_TSTRB_EN: zero the bytes of each write whose TSTRB bit is clear.
module fetch_unit_s00_axis
  import fetch_unit_s00_axis_pkg::*;
#(
  parameter int unsigned BRAM_DEPTH           = 10,
  parameter int unsigned INSTR_BRAM_DEPTH     = 11,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned COL_BITS             = ColBitsDefault
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  fetch_unit_s00_axis_if.slave            s_axis,
  input  logic [1:0]                      bram_sel,
  input  logic [31:0]                     row_width,
  output logic [BRAM_DEPTH-1:0]           mat_a_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] mat_a_din,
  output logic                            mat_a_en,
  output logic [BRAM_DEPTH-1:0]           mat_b_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] mat_b_din,
  output logic                            mat_b_en,
  output logic [INSTR_BRAM_DEPTH-1:0]     instr_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] instr_din,
  output logic                            instr_en,
  output logic                            VALID_FU2PE
);

  state_e state_q, state_d;
  logic   first_q;
  sel_e   sel_q;
  logic [31:0] rw_q;
  logic   valid_q;

  logic accept, last_beat;
  sel_e cur_sel;
  logic [31:0] cur_rw;
  logic [BRAM_DEPTH-1:0] mat_addr;
  logic [INSTR_BRAM_DEPTH-1:0] lin_addr;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] wr_data;

  logic [BRAM_DEPTH-1:0]           mat_a_addr_q, mat_b_addr_q;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] mat_a_din_q, mat_b_din_q, instr_din_q;
  logic [INSTR_BRAM_DEPTH-1:0]     instr_addr_q;
  logic                            mat_a_en_q, mat_b_en_q, instr_en_q;

  assign s_axis.TREADY = (state_q == StRecv) && !S_AXIS_ARESETN;
  assign accept        = s_axis.TVALID && s_axis.TREADY;
  assign last_beat     = accept && s_axis.TLAST;

  // The first beat of a packet uses the live sideband; later beats use the latched copy.
  assign cur_sel = first_q ? sel_e'(bram_sel) : sel_q;
  assign cur_rw  = first_q ? row_width : rw_q;

`ifdef FETCH_UNIT_TSTRB_EN
  assign wr_data = strb_mask(s_axis.TDATA, s_axis.TSTRB);
`else
  logic unused_tstrb;
  assign unused_tstrb = ^s_axis.TSTRB;
  assign wr_data      = s_axis.TDATA;
`endif

  fetch_addr_gen #(
    .BramDepth (BRAM_DEPTH),
    .InstrDepth(INSTR_BRAM_DEPTH),
    .ColBits   (COL_BITS)
  ) u_addr_gen (
    .clk_i       (S_AXIS_ACLK),
    .rst_i       (S_AXIS_ARESETN),
    .beat_i      (accept),
    .last_i      (s_axis.TLAST),
    .width_i     (cur_rw),
    .mat_addr_o  (mat_addr),
    .instr_addr_o(lin_addr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRecv:  if (last_beat) state_d = StDone;
      StDone:  state_d = StRecv;
      default: state_d = StRecv;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESETN) begin
      state_q <= StRecv;
      first_q <= 1'b1;
      sel_q   <= SelMatA;
      rw_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == StDone) && (sel_q != SelNone);
      if (accept) begin
        if (first_q) begin
          sel_q <= sel_e'(bram_sel);
          rw_q  <= row_width;
        end
        first_q <= s_axis.TLAST;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESETN) begin
      mat_a_addr_q <= '0;
      mat_a_din_q  <= '0;
      mat_a_en_q   <= 1'b0;
      mat_b_addr_q <= '0;
      mat_b_din_q  <= '0;
      mat_b_en_q   <= 1'b0;
      instr_addr_q <= '0;
      instr_din_q  <= '0;
      instr_en_q   <= 1'b0;
    end else begin
      mat_a_en_q <= accept && (cur_sel == SelMatA);
      mat_b_en_q <= accept && (cur_sel == SelMatB);
      instr_en_q <= accept && (cur_sel == SelInstr);
      if (accept && (cur_sel == SelMatA)) begin
        mat_a_addr_q <= mat_addr;
        mat_a_din_q  <= wr_data;
      end
      if (accept && (cur_sel == SelMatB)) begin
        mat_b_addr_q <= mat_addr;
        mat_b_din_q  <= wr_data;
      end
      if (accept && (cur_sel == SelInstr)) begin
        instr_addr_q <= lin_addr;
        instr_din_q  <= wr_data;
      end
    end
  end

  assign mat_a_addr  = mat_a_addr_q;
  assign mat_a_din   = mat_a_din_q;
  assign mat_a_en    = mat_a_en_q;
  assign mat_b_addr  = mat_b_addr_q;
  assign mat_b_din   = mat_b_din_q;
  assign mat_b_en    = mat_b_en_q;
  assign instr_addr  = instr_addr_q;
  assign instr_din   = instr_din_q;
  assign instr_en    = instr_en_q;
  assign VALID_FU2PE = valid_q;

endmodule

// File: tb/tb_fetch_unit_s00_axis.sv
// Randomized self-checking bench for fetch_unit_s00_axis against a packet-level address model.
module tb_fetch_unit_s00_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_d1 = 1'b1;
  logic [1:0]  bram_sel = '0;
  logic [31:0] row_width = '0;
  logic [9:0]  mat_a_addr, mat_b_addr;
  logic [31:0] mat_a_din, mat_b_din, instr_din;
  logic [10:0] instr_addr;
  logic        mat_a_en, mat_b_en, instr_en, valid_fu2pe;

  fetch_unit_s00_axis_if axis_if ();

  fetch_unit_s00_axis dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst),
    .s_axis        (axis_if),
    .bram_sel      (bram_sel),
    .row_width     (row_width),
    .mat_a_addr    (mat_a_addr),
    .mat_a_din     (mat_a_din),
    .mat_a_en      (mat_a_en),
    .mat_b_addr    (mat_b_addr),
    .mat_b_din     (mat_b_din),
    .mat_b_en      (mat_b_en),
    .instr_addr    (instr_addr),
    .instr_din     (instr_din),
    .instr_en      (instr_en),
    .VALID_FU2PE   (valid_fu2pe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_d1 <= rst;

  int n_checks = 0;
  int n_errors = 0;
  int valid_seen = 0;
  int pulses_exp = 0;
  logic [63:0] exp_q[$];
  logic [41:0] prev_a = '0, prev_b = '0;
  logic [42:0] prev_i = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected write for beat k of a packet: {port, addr, data}.
  function automatic logic [63:0] model_write(input int sel, input int w, input int k,
                                              input logic [31:0] d, input logic [3:0] s);
    int addr;
    logic [31:0] dd;
    if (sel == 2) addr = k % 2048;
    else          addr = ((k / w) % 32) * 32 + (k % w);
    dd = d;
    for (int b = 0; b < 4; b++) if (!s[b]) dd[b*8 +: 8] = 8'h00;
    return {19'd0, 2'(sel), 11'(addr), dd};
  endfunction

  always @(negedge clk) begin
    int n_en;
    logic [63:0] obs, e;
    n_en = int'(mat_a_en) + int'(mat_b_en) + int'(instr_en);
    obs  = '0;
    if (mat_a_en)      obs = {19'd0, 2'd0, 1'b0, mat_a_addr, mat_a_din};
    else if (mat_b_en) obs = {19'd0, 2'd1, 1'b0, mat_b_addr, mat_b_din};
    else if (instr_en) obs = {19'd0, 2'd2, instr_addr, instr_din};
    if (!rst_d1) begin
      if (n_en > 1) check_eq("one_hot_en", 64'(n_en), 64'd1);
      if (n_en != 0) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_write", 64'(n_en), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("write", obs, e);
        end
      end
      if (!mat_a_en) check_eq("hold_a", 64'({mat_a_addr, mat_a_din}), 64'(prev_a));
      if (!mat_b_en) check_eq("hold_b", 64'({mat_b_addr, mat_b_din}), 64'(prev_b));
      if (!instr_en) check_eq("hold_i", 64'({instr_addr, instr_din}), 64'(prev_i));
      if (valid_fu2pe) valid_seen++;
    end
    prev_a = {mat_a_addr, mat_a_din};
    prev_b = {mat_b_addr, mat_b_din};
    prev_i = {instr_addr, instr_din};
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a"}, 64'({mat_a_addr, mat_a_din, mat_a_en}), 64'd0);
    check_eq({tag, "_b"}, 64'({mat_b_addr, mat_b_din, mat_b_en}), 64'd0);
    check_eq({tag, "_i"}, 64'({instr_addr, instr_din, instr_en, valid_fu2pe, axis_if.TREADY}),
             64'd0);
  endtask

  task automatic send_pkt(input int sel, input logic [31:0] rw, input int n, input int gap_pos,
                          input int gap_len, input int abort_at, input bit scramble,
                          input bit fixed);
    int w;
    logic [31:0] d;
    logic [3:0] s, es;
    bit acc;
    int tries;
    w = (rw == 0) ? 1 : ((rw > 32) ? 32 : int'(rw));
    bram_sel  = 2'(sel);
    row_width = rw;
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        axis_if.TVALID = 1'b0;
        axis_if.TLAST  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid_pkt");
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (k == gap_pos) begin
        axis_if.TVALID = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      d = fixed ? 32'hAABBCCDD : $urandom;
      s = fixed ? 4'b0011 : 4'($urandom);
      axis_if.TDATA  = d;
      axis_if.TSTRB  = s;
      axis_if.TLAST  = (k == n - 1);
      axis_if.TVALID = 1'b1;
      if (scramble && k > 0) begin
        bram_sel  = 2'($urandom);
        row_width = $urandom_range(0, 40);
      end
`ifdef FETCH_UNIT_TSTRB_EN
      es = s;
`else
      es = 4'hF;
`endif
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 8) begin
        @(negedge clk);
        acc = axis_if.TREADY;
        if (acc && sel != 3) exp_q.push_back(model_write(sel, w, k, d, es));
        @(posedge clk);
        #1;
        tries++;
      end
      if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
    end
    axis_if.TVALID = 1'b0;
    axis_if.TLAST  = 1'b0;
    if (sel != 3) pulses_exp++;
    @(negedge clk);
    check_eq("tready_done", 64'(axis_if.TREADY), 64'd0);
    check_eq("valid_early", 64'(valid_fu2pe), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("valid_pulse", 64'(valid_fu2pe), 64'(sel != 3));
    check_eq("tready_back", 64'(axis_if.TREADY), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("valid_end", 64'(valid_fu2pe), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    axis_if.TDATA  = '0;
    axis_if.TSTRB  = '0;
    axis_if.TLAST  = 1'b0;
    axis_if.TVALID = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_init");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send_pkt(0, 2, 16, -1, 0, -1, 0, 0);      // mat A, two per row
    send_pkt(1, 5, 15, -1, 0, -1, 0, 0);      // mat B, five per row
    send_pkt(2, 5, 15, -1, 0, -1, 0, 0);      // instr, linear
    send_pkt(2, 5, 4, -1, 0, -1, 0, 0);       // instr restarts at 0
    send_pkt(0, 3, 10, 4, 3, -1, 0, 0);       // TVALID gap mid-packet
    send_pkt(0, 3, 8, -1, 0, 5, 0, 0);        // reset after 5 beats
    send_pkt(0, 3, 4, -1, 0, -1, 0, 0);       // restarts at address 0
    send_pkt(3, 2, 4, -1, 0, -1, 0, 0);       // discarded packet
    send_pkt(0, 4, 1, -1, 0, -1, 0, 1);       // strobe pattern on fixed data
    send_pkt(0, 0, 40, -1, 0, -1, 0, 0);      // zero width, row wrap
    send_pkt(1, 32'd1000, 70, -1, 0, -1, 0, 0); // clamped width
    send_pkt(2, 0, 2050, -1, 0, -1, 0, 0);    // instruction address wrap

    for (int p = 0; p < 14; p++) begin
      int sel, n, gp;
      logic [31:0] rw;
      sel = $urandom_range(0, 3);
      n   = $urandom_range(1, 40);
      case ($urandom_range(0, 4))
        0:       rw = 0;
        1:       rw = 32;
        2:       rw = 32'(33 + $urandom_range(0, 100));
        3:       rw = $urandom;
        default: rw = $urandom_range(1, 31);
      endcase
      gp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : -1;
      send_pkt(sel, rw, n, gp, $urandom_range(1, 4), -1, 1, 0);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    check_eq("valid_count", 64'(valid_seen), 64'(pulses_exp));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
